// File: rtl/cond_exec_stage.sv
// cond_exec_stage: execute-stage condition unit of the 5-stage ARM pipeline.
// Holds the architectural NZCV flags and tests each instruction's condition
// field against them. Side effects (PCSrc, RegWrite, MemWrite, flag update)
// are gated by that test. The gated controls are registered into the E->M
// pipeline register. Valid instructions that fail their condition are counted
// in a saturating squash counter.
//
// Ports:
//   clk, reset             pipeline clock; synchronous active-high reset
//   StallE, FlushM         hold the E stage / load a bubble into M
//   ValidE, CondE          E instruction valid flag and condition field
//   FlagWriteE             [1] writes N,Z; [0] writes C,V
//   ALUFlags               {N,Z,C,V} produced by the ALU this cycle
//   PCSrcE/RegWriteE/MemWriteE  ungated decode controls
//   CondExE                combinational condition-pass for the E instruction
//   Flags                  architectural NZCV register
//   ValidM/PCSrcM/RegWriteM/MemWriteM  registered, gated M-stage controls
//   SquashCount            saturating count of condition-failed instructions
module cond_exec_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushM,
  input  logic             ValidE,
  input  logic [3:0]       CondE,
  input  logic [1:0]       FlagWriteE,
  input  logic [3:0]       ALUFlags,
  input  logic             PCSrcE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  output logic             CondExE,
  output logic [3:0]       Flags,
  output logic             ValidM,
  output logic             PCSrcM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [CNT_W-1:0] SquashCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;
  logic go;

  assign {flag_n, flag_z, flag_c, flag_v} = Flags;

  // Condition decode against the registered flags only (no ALU bypass).
  always_comb begin
    CondExE = 1'b1;
    case (CondE)
      4'b0000: CondExE = flag_z;
      4'b0001: CondExE = ~flag_z;
      4'b0010: CondExE = flag_c;
      4'b0011: CondExE = ~flag_c;
      4'b0100: CondExE = flag_n;
      4'b0101: CondExE = ~flag_n;
      4'b0110: CondExE = flag_v;
      4'b0111: CondExE = ~flag_v;
      4'b1000: CondExE = flag_c & ~flag_z;
      4'b1001: CondExE = ~flag_c | flag_z;
      4'b1010: CondExE = (flag_n == flag_v);
      4'b1011: CondExE = (flag_n != flag_v);
      4'b1100: CondExE = ~flag_z & (flag_n == flag_v);
      4'b1101: CondExE = flag_z | (flag_n != flag_v);
      default: CondExE = 1'b1;
    endcase
  end

  assign go = ValidE & CondExE;

  // Architectural flags: N,Z and C,V halves written independently.
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else if (!StallE && go) begin
      if (FlagWriteE[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagWriteE[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Squash counter saturates at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      SquashCount <= '0;
    end else if (!StallE && ValidE && !CondExE && (SquashCount != CNT_MAX)) begin
      SquashCount <= SquashCount + CNT_W'(1);
    end
  end

  // E->M register; flush takes priority over stall.
  always_ff @(posedge clk) begin
    if (reset || FlushM) begin
      ValidM    <= 1'b0;
      PCSrcM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end else if (!StallE) begin
      ValidM    <= ValidE;
      PCSrcM    <= PCSrcE & go;
      RegWriteM <= RegWriteE & go;
      MemWriteM <= MemWriteE & go;
    end
  end

endmodule

// File: tb/tb_cond_exec_stage.sv
// Self-checking bench for cond_exec_stage: directed scenarios plus randomized
// traffic, checked against a cycle-level behavioural model of the stage.
module tb_cond_exec_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallE = 1'b0;
  logic        FlushM = 1'b0;
  logic        ValidE = 1'b0;
  logic [3:0]  CondE = 4'b0;
  logic [1:0]  FlagWriteE = 2'b0;
  logic [3:0]  ALUFlags = 4'b0;
  logic        PCSrcE = 1'b0;
  logic        RegWriteE = 1'b0;
  logic        MemWriteE = 1'b0;

  logic        CondExE;
  logic [3:0]  Flags;
  logic        ValidM, PCSrcM, RegWriteM, MemWriteM;
  logic [15:0] SquashCount;

  logic        CondExE4;
  logic [3:0]  Flags4;
  logic        ValidM4, PCSrcM4, RegWriteM4, MemWriteM4;
  logic [3:0]  SquashCount4;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic [3:0] m_flags;
  logic       m_validm, m_pcsrcm, m_regwm, m_memwm;
  int         m_cnt16, m_cnt4;

  always #5 clk = ~clk;

  cond_exec_stage dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushM(FlushM),
    .ValidE(ValidE), .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .CondExE(CondExE), .Flags(Flags), .ValidM(ValidM), .PCSrcM(PCSrcM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .SquashCount(SquashCount)
  );

  cond_exec_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushM(FlushM),
    .ValidE(ValidE), .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .CondExE(CondExE4), .Flags(Flags4), .ValidM(ValidM4), .PCSrcM(PCSrcM4),
    .RegWriteM(RegWriteM4), .MemWriteM(MemWriteM4), .SquashCount(SquashCount4)
  );

  // ARM condition semantics, by mnemonic.
  function automatic bit cond_pass(input logic [3:0] code, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code)
      4'd0:  return z;                 // EQ
      4'd1:  return !z;                // NE
      4'd2:  return c;                 // CS
      4'd3:  return !c;                // CC
      4'd4:  return n;                 // MI
      4'd5:  return !n;                // PL
      4'd6:  return v;                 // VS
      4'd7:  return !v;                // VC
      4'd8:  return c && !z;           // HI
      4'd9:  return !c || z;           // LS
      4'd10: return n == v;            // GE
      4'd11: return n != v;            // LT
      4'd12: return !z && (n == v);    // GT
      4'd13: return z || (n != v);     // LE
      default: return 1'b1;            // AL
    endcase
  endfunction

  function automatic logic [7:0] exp_state();
    return {m_flags, m_validm, m_pcsrcm, m_regwm, m_memwm};
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic cycle();
    bit pass, go;
    pass = cond_pass(CondE, m_flags);
    go = ValidE && pass;
    if (reset) begin
      m_flags = 4'b0; m_validm = 0; m_pcsrcm = 0; m_regwm = 0; m_memwm = 0;
      m_cnt16 = 0; m_cnt4 = 0;
    end else begin
      if (!StallE) begin
        if (go && FlagWriteE[1]) m_flags[3:2] = ALUFlags[3:2];
        if (go && FlagWriteE[0]) m_flags[1:0] = ALUFlags[1:0];
        if (ValidE && !pass) begin
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt4 < 15) m_cnt4++;
        end
      end
      if (FlushM) begin
        m_validm = 0; m_pcsrcm = 0; m_regwm = 0; m_memwm = 0;
      end else if (!StallE) begin
        m_validm = ValidE;
        m_pcsrcm = PCSrcE && go;
        m_regwm  = RegWriteE && go;
        m_memwm  = MemWriteE && go;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; StallE = 0; FlushM = 0; ValidE = 0; CondE = 4'hE;
    FlagWriteE = 2'b00; ALUFlags = 4'b0; PCSrcE = 0; RegWriteE = 0; MemWriteE = 0;
  endtask

  // Load the flags with an unconditional flag-setting instruction.
  task automatic load_flags(input logic [3:0] f);
    idle();
    ValidE = 1; CondE = 4'hE; FlagWriteE = 2'b11; ALUFlags = f;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      StallE = 1'($urandom); FlushM = 1'($urandom); ValidE = 1'($urandom);
      CondE = 4'($urandom); FlagWriteE = 2'($urandom); ALUFlags = 4'($urandom);
      PCSrcE = 1'($urandom); RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
      cycle();
    end
    n_cmp++;
    if ({Flags, ValidM, PCSrcM, RegWriteM, MemWriteM} !== 8'h00) begin
      n_err++; $display("FAIL reset_state: got %b required 00000000", {Flags, ValidM, PCSrcM, RegWriteM, MemWriteM});
    end
    n_cmp++;
    if (SquashCount !== 16'd0 || SquashCount4 !== 4'd0) begin
      n_err++; $display("FAIL reset_count: got %0d/%0d required 0/0", SquashCount, SquashCount4);
    end
    idle();
    CondE = 4'b0001; #1;
    n_cmp++;
    if (CondExE !== 1'b1) begin n_err++; $display("FAIL reset_ne: got %b required 1", CondExE); end
    CondE = 4'b0000; #1;
    n_cmp++;
    if (CondExE !== 1'b0) begin n_err++; $display("FAIL reset_eq: got %b required 0", CondExE); end
    CondE = 4'b1110; #1;
    n_cmp++;
    if (CondExE !== 1'b1) begin n_err++; $display("FAIL reset_al: got %b required 1", CondExE); end
  endtask

  task automatic test_cmp_beq();
    idle();
    ValidE = 1; CondE = 4'b1110; FlagWriteE = 2'b11; ALUFlags = 4'b0100;
    cycle();
    n_cmp++;
    if (Flags !== 4'b0100) begin n_err++; $display("FAIL cmp_flags: got %b required 0100", Flags); end
    idle();
    ValidE = 1; CondE = 4'b0000; PCSrcE = 1; #1;
    n_cmp++;
    if (CondExE !== 1'b1) begin n_err++; $display("FAIL beq_condex: got %b required 1", CondExE); end
    cycle();
    n_cmp++;
    if (PCSrcM !== 1'b1 || ValidM !== 1'b1) begin
      n_err++; $display("FAIL beq_pcsrcm: got pcsrc=%b valid=%b required 1/1", PCSrcM, ValidM);
    end
  endtask

  task automatic test_partial_flags();
    load_flags(4'b1111);
    ValidE = 1; FlagWriteE = 2'b01; ALUFlags = 4'b0000;
    cycle();
    n_cmp++;
    if (Flags !== 4'b1100) begin n_err++; $display("FAIL partial_cv: got %b required 1100", Flags); end
    FlagWriteE = 2'b10;
    cycle();
    n_cmp++;
    if (Flags !== 4'b0000) begin n_err++; $display("FAIL partial_nz: got %b required 0000", Flags); end
    idle();
  endtask

  task automatic test_cond_fail();
    int c0;
    load_flags(4'b0000);
    c0 = m_cnt16;
    ValidE = 1; CondE = 4'b0000; RegWriteE = 1; MemWriteE = 1; PCSrcE = 1;
    FlagWriteE = 2'b11; ALUFlags = 4'b1111; #1;
    n_cmp++;
    if (CondExE !== 1'b0) begin n_err++; $display("FAIL fail_condex: got %b required 0", CondExE); end
    cycle();
    n_cmp++;
    if ({ValidM, PCSrcM, RegWriteM, MemWriteM} !== 4'b1000 || Flags !== 4'b0000) begin
      n_err++; $display("FAIL fail_gating: got M=%b flags=%b required 1000/0000", {ValidM, PCSrcM, RegWriteM, MemWriteM}, Flags);
    end
    n_cmp++;
    if (SquashCount !== 16'(c0 + 1)) begin
      n_err++; $display("FAIL fail_count: got %0d required %0d", SquashCount, c0 + 1);
    end
    idle();
  endtask

  task automatic test_stall_flush();
    logic [7:0]  snap;
    logic [15:0] csnap;
    load_flags(4'b0001);
    ValidE = 1; CondE = 4'hE; RegWriteE = 1; MemWriteE = 1;
    cycle();
    snap = {Flags, ValidM, PCSrcM, RegWriteM, MemWriteM};
    csnap = SquashCount;
    idle();
    StallE = 1; ValidE = 1; CondE = 4'hE; FlagWriteE = 2'b11; ALUFlags = 4'b1010; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if ({Flags, ValidM, PCSrcM, RegWriteM, MemWriteM} !== snap || SquashCount !== csnap) begin
        n_err++; $display("FAIL stall_hold[%0d]: got %b/%0d required %b/%0d", i,
          {Flags, ValidM, PCSrcM, RegWriteM, MemWriteM}, SquashCount, snap, csnap);
      end
    end
    FlushM = 1;
    cycle();
    n_cmp++;
    if ({ValidM, PCSrcM, RegWriteM, MemWriteM} !== 4'b0000 || Flags !== snap[7:4]) begin
      n_err++; $display("FAIL stall_flush: got M=%b flags=%b required 0000/%b",
        {ValidM, PCSrcM, RegWriteM, MemWriteM}, Flags, snap[7:4]);
    end
    idle();
  endtask

  task automatic test_saturation();
    load_flags(4'b0000);
    ValidE = 1; CondE = 4'b0000;
    for (int i = 0; i < 20; i++) cycle();
    n_cmp++;
    if (SquashCount4 !== 4'd15) begin n_err++; $display("FAIL sat_cnt4: got %0d required 15", SquashCount4); end
    n_cmp++;
    if (SquashCount !== 16'(m_cnt16)) begin
      n_err++; $display("FAIL sat_cnt16: got %0d required %0d", SquashCount, m_cnt16);
    end
    idle();
  endtask

  task automatic test_decode_exhaustive();
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      n_cmp++;
      if (Flags !== 4'(f)) begin n_err++; $display("FAIL dec_flags: got %b required %b", Flags, 4'(f)); end
      for (int c = 0; c < 16; c++) begin
        CondE = 4'(c); #1;
        n_cmp++;
        if (CondExE !== cond_pass(4'(c), 4'(f))) begin
          n_err++; $display("FAIL decode cond=%b flags=%b: got %b required %b", 4'(c), 4'(f), CondExE, cond_pass(4'(c), 4'(f)));
        end
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      StallE = ($urandom_range(0, 3) == 0);
      FlushM = ($urandom_range(0, 5) == 0);
      ValidE = ($urandom_range(0, 3) != 0);
      CondE = 4'($urandom); FlagWriteE = 2'($urandom); ALUFlags = 4'($urandom);
      PCSrcE = 1'($urandom); RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
      #1;
      n_cmp++;
      if (CondExE !== cond_pass(CondE, m_flags)) begin
        n_err++; $display("FAIL rnd_condex[%0d]: got %b required %b", i, CondExE, cond_pass(CondE, m_flags));
      end
      cycle();
      n_cmp++;
      if ({Flags, ValidM, PCSrcM, RegWriteM, MemWriteM} !== exp_state() ||
          {Flags4, ValidM4, PCSrcM4, RegWriteM4, MemWriteM4} !== exp_state()) begin
        n_err++; $display("FAIL rnd_state[%0d]: got %b/%b required %b", i,
          {Flags, ValidM, PCSrcM, RegWriteM, MemWriteM},
          {Flags4, ValidM4, PCSrcM4, RegWriteM4, MemWriteM4}, exp_state());
      end
      n_cmp++;
      if (SquashCount !== 16'(m_cnt16) || SquashCount4 !== 4'(m_cnt4) || CondExE4 !== CondExE) begin
        n_err++; $display("FAIL rnd_count[%0d]: got %0d/%0d required %0d/%0d", i,
          SquashCount, SquashCount4, m_cnt16, m_cnt4);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_cmp_beq();
    test_partial_flags();
    test_cond_fail();
    test_stall_flush();
    test_saturation();
    test_decode_exhaustive();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cond_exec_stage.md
# cond_exec_stage

Execute-stage condition unit of the 5-stage ARM pipeline. Holds the architectural NZCV flags and evaluates each instruction's 4-bit condition field against them. It gates the instruction's side effects (PCSrc, RegWrite, MemWrite, flag update) and registers the gated controls into the E→M pipeline register. It also counts condition-failed (squashed) instructions for performance monitoring.

## Interface
- CNT_W, 16, width of the saturating squash counter

- clk  in  1  pipeline clock; all state updates on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- StallE  in  1  hold E stage: flags, counter and M register keep their values
- FlushM  in  1  load a bubble into the M register
- ValidE  in  1  an instruction occupies E this cycle
- CondE  in  4  condition field of the E instruction
- FlagWriteE  in  2  [1]: update N,Z; [0]: update C,V
- ALUFlags  in  4  NZCV produced by the ALU this cycle ({N,Z,C,V})
- PCSrcE, RegWriteE, MemWriteE  in  1 each  ungated control from decode
- CondExE  out  1  combinational: condition passes for the E instruction
- Flags  out  4  current architectural NZCV register
- ValidM  out  1  registered: M holds a real instruction
- PCSrcM, RegWriteM, MemWriteM  out  1 each  registered, condition-gated controls
- SquashCount  out  CNT_W  saturating count of condition-failed valid instructions

## Operation
- Condition decode, using the Flags register only (N,Z,C,V = Flags[3:0]):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 also 1 (unconditional).
- CondExE is computed from CondE and Flags regardless of ValidE. Downstream ignores it when ValidE=0.
- Let go = ValidE & CondExE.
- Flag update, when go & !StallE:
  - FlagWriteE[1] loads Flags[3:2] ← ALUFlags[3:2].
  - FlagWriteE[0] loads Flags[1:0] ← ALUFlags[1:0].
  - The two halves are independent; both may write in the same cycle.
- M register, when !StallE or FlushM:
  - FlushM=1: ValidM, PCSrcM, RegWriteM and MemWriteM all load 0.
  - Otherwise: ValidM←ValidE; PCSrcM←PCSrcE&go; RegWriteM←RegWriteE&go; MemWriteM←MemWriteE&go.
- Squash counter: increments when ValidE & !CondExE & !StallE. It holds at 2^CNT_W−1 and never wraps.

## Timing
- reset=1 at posedge: Flags=0000, ValidM=0, PCSrcM=RegWriteM=MemWriteM=0, SquashCount=0.
  - reset overrides StallE, FlushM and all writes.
  - Reset mid-operation discards the in-flight E instruction's effects.
- After reset, CondExE settles combinationally from Flags=0000: EQ fails, NE passes, AL passes.
- Flag latency is one cycle.
  - A flag-setting instruction in E at cycle t updates Flags at the t→t+1 edge.
  - The instruction in E at t+1 evaluates against the new flags, so back-to-back CMP→BEQ needs no stall.
  - The E instruction never sees its own ALUFlags; there is no same-cycle bypass.
- Control latency is one cycle: E controls appear on the *M outputs after the next posedge.
- Simultaneous events:
  - StallE & FlushM: the M register flushes to a bubble; flags and counter hold.
  - Condition fail with FlagWriteE≠00: no flag update. The instruction still advances to M as a valid no-op with all gated controls 0.

## Test plan
- Reset: drive reset for 2 cycles with random inputs → Flags=0000, ValidM=0, SquashCount=0. CondE=0001 then gives CondExE=1.
- CMP then BEQ:
  - Cycle t: ValidE=1, CondE=1110, FlagWriteE=11, ALUFlags=0100 → Flags=0100 at t+1.
  - Cycle t+1: CondE=0000, PCSrcE=1 → CondExE=1, and PCSrcM=1 at t+2.
- Partial flag write: Flags=1111, then FlagWriteE=01, ALUFlags=0000 → Flags=1100. Next, FlagWriteE=10, ALUFlags=0000 → Flags=0000.
- Condition fail: Flags=0000, CondE=0000, ValidE=1, RegWriteE=MemWriteE=1, FlagWriteE=11, ALUFlags=1111 → RegWriteM=MemWriteM=0, ValidM=1, Flags remain 0000, SquashCount increments by 1.
- Stall/flush:
  - StallE=1 for 3 cycles with a flag-setting valid instruction → Flags, SquashCount and the M outputs unchanged.
  - Then StallE=1 with FlushM=1 → ValidM=0 and all *M outputs 0.
- Saturation: CNT_W=4, 20 consecutive failing valid instructions → SquashCount stops at 15. Exhaustively check all 16 CondE codes against all 16 Flags values versus the decode table.
